// File: rtl/cdc_pkg.sv
// Shared CDC constants and helpers for the synchroniser family.
package cdc_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int FILTER_MAX = 255;

  // Filter counter width: counts 0..FILTER-1. Kept at least 1 bit wide so
  // the declaration stays legal when the filter is disabled.
  function automatic int cnt_w(input int filter);
    return (filter < 1) ? 1 : $clog2(filter + 1);
  endfunction

endpackage

// File: rtl/sync_nff_ch.sv
// One synchroniser channel: flop chain, optional stability filter, edge pulses.
module sync_nff_ch
  import cdc_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter int   FILTER  = 0,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic chg
);

  (* async_reg = "true" *) logic [STAGES-1:0] s_q;

  logic q_nxt;   // value q takes after the coming edge
  logic rise_d, fall_d;
  logic rise_q, fall_q, chg_q;

  // Synchroniser chain; s_q[0] is the only flop that may go metastable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_q <= {STAGES{RST_VAL}};
    else      s_q <= {s_q[STAGES-2:0], d};
  end

  if (FILTER == 0) begin : g_nofilt
    // q is the last chain flop directly; its next value is the stage before.
    assign q     = s_q[STAGES-1];
    assign q_nxt = s_q[STAGES-2];
  end else begin : g_filt
    localparam int CW = cnt_w(FILTER);

    logic          sy;
    logic          q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign sy = s_q[STAGES-1];

    // Accept a new level only after it has differed from q for FILTER
    // consecutive cycles; any bounce back restarts the count.
    always_comb begin
      q_d   = q_q;
      cnt_d = '0;
      if (sy != q_q) begin
        if (cnt_q == CW'(FILTER - 1)) q_d = sy;
        else                          cnt_d = cnt_q + CW'(1);
      end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q_q   <= RST_VAL;
        cnt_q <= '0;
      end else begin
        q_q   <= q_d;
        cnt_q <= cnt_d;
      end
    end

    assign q     = q_q;
    assign q_nxt = q_d;
  end

  assign rise_d = q_nxt & ~q;
  assign fall_d = ~q_nxt & q;

  // Edge pulses registered so they line up with q showing its new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= rise_d | fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
  assign chg  = chg_q;

endmodule

// File: rtl/sync_nff_filt.sv
// Multi-channel synchroniser with optional stability filter and edge pulses.
// Channels are independent; never pass a multi-bit bus through this block.
module sync_nff_filt
  import cdc_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter int               FILTER  = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] chg
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sync_nff_filt: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
  end

  if (FILTER < 0 || FILTER > FILTER_MAX) begin : g_bad_filter
    $error("sync_nff_filt: FILTER=%0d outside 0..%0d", FILTER, FILTER_MAX);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_nff_ch #(
      .STAGES  (STAGES),
      .FILTER  (FILTER),
      .RST_VAL (RST_VAL[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .d    (d[i]),
      .q    (q[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .chg  (chg[i])
    );
  end

endmodule

// File: tb/tb_sync_nff_filt.sv
// Directed bench: three configurations of sync_nff_filt on one clock.
module tb_sync_nff_filt;

  logic       clk;
  logic       rst;
  logic [3:0] dA, qA, riseA, fallA, chgA;   // S2 F0 R0000
  logic [3:0] dB, qB, riseB, fallB, chgB;   // S3 F4 R0000
  logic [3:0] dC, qC, riseC, fallC, chgC;   // S2 F0 R1111

  int checks = 0;
  int errors = 0;

  sync_nff_filt #(.WIDTH(4), .STAGES(2), .FILTER(0), .RST_VAL(4'b0000)) u_a (
    .clk(clk), .rst(rst), .d(dA), .q(qA), .rise(riseA), .fall(fallA), .chg(chgA));
  sync_nff_filt #(.WIDTH(4), .STAGES(3), .FILTER(4), .RST_VAL(4'b0000)) u_b (
    .clk(clk), .rst(rst), .d(dB), .q(qB), .rise(riseB), .fall(fallB), .chg(chgB));
  sync_nff_filt #(.WIDTH(4), .STAGES(2), .FILTER(0), .RST_VAL(4'b1111)) u_c (
    .clk(clk), .rst(rst), .d(dC), .q(qC), .rise(riseC), .fall(fallC), .chg(chgC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; dA = 4'h0; dB = 4'h0; dC = 4'hF;
    repeat (3) tick();
    checks++;
    if (qA !== 4'h0 || riseA !== 4'h0 || fallA !== 4'h0 || chgA !== 4'h0) begin
      errors++; $display("FAIL reset_A q=%h r=%h f=%h c=%h want 0", qA, riseA, fallA, chgA);
    end
    checks++;
    if (qB !== 4'h0 || riseB !== 4'h0 || fallB !== 4'h0 || chgB !== 4'h0) begin
      errors++; $display("FAIL reset_B q=%h r=%h f=%h c=%h want 0", qB, riseB, fallB, chgB);
    end
    checks++;
    if (qC !== 4'hF || riseC !== 4'h0 || fallC !== 4'h0 || chgC !== 4'h0) begin
      errors++; $display("FAIL reset_C q=%h r=%h f=%h c=%h want q=f pulses 0", qC, riseC, fallC, chgC);
    end
    rst = 1'b1;
    // C holds d == RST_VAL across release: no pulse may appear.
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (qC !== 4'hF || riseC !== 4'h0 || fallC !== 4'h0 || chgC !== 4'h0) begin
        errors++; $display("FAIL rstval_quiet cyc%0d q=%h r=%h f=%h c=%h want q=f pulses 0",
                           k, qC, riseC, fallC, chgC);
      end
    end
  endtask

  task automatic test_basic();
    dA = 4'b0101;
    tick();  // E1
    checks++;
    if (qA !== 4'h0 || riseA !== 4'h0) begin
      errors++; $display("FAIL basic_e1 q=%h r=%h want 0 0", qA, riseA);
    end
    tick();  // E2
    checks++;
    if (qA !== 4'b0101 || riseA !== 4'b0101 || fallA !== 4'h0 || chgA !== 4'b0101) begin
      errors++; $display("FAIL basic_e2 q=%h r=%h f=%h c=%h want 5 5 0 5", qA, riseA, fallA, chgA);
    end
    tick();  // E3: pulse one cycle wide
    checks++;
    if (qA !== 4'b0101 || riseA !== 4'h0 || chgA !== 4'h0) begin
      errors++; $display("FAIL basic_e3 q=%h r=%h c=%h want 5 0 0", qA, riseA, chgA);
    end
    dA = 4'h0;
    tick(); tick();
    checks++;
    if (qA !== 4'h0 || fallA !== 4'b0101 || riseA !== 4'h0 || chgA !== 4'b0101) begin
      errors++; $display("FAIL basic_fall q=%h r=%h f=%h c=%h want 0 0 5 5", qA, riseA, fallA, chgA);
    end
    repeat (3) tick();
  endtask

  task automatic test_toggle();
    int nchg;
    logic exp_rise;
    logic exp_p;
    nchg = 0;
    exp_rise = 1'b1;
    for (int t = 1; t <= 28; t++) begin
      if ((t - 1) % 3 == 0 && t <= 22) dA[1] = ~dA[1];
      tick();
      exp_p = (t % 3 == 2) && (t <= 23);
      checks++;
      if (chgA[1] !== exp_p || riseA[1] !== (exp_p & exp_rise) || fallA[1] !== (exp_p & ~exp_rise)) begin
        errors++; $display("FAIL toggle t%0d c=%b r=%b f=%b want c=%b r=%b", t, chgA[1], riseA[1],
                           fallA[1], exp_p, exp_p & exp_rise);
      end
      if (chgA[1] === 1'b1) nchg++;
      if (exp_p) exp_rise = ~exp_rise;
    end
    checks++;
    if (nchg != 8) begin
      errors++; $display("FAIL toggle_count got %0d want 8", nchg);
    end
  endtask

  task automatic test_glitch();
    dB = 4'b0001;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3) dB = 4'h0;
      checks++;
      if (qB !== 4'h0 || riseB !== 4'h0 || fallB !== 4'h0 || chgB !== 4'h0) begin
        errors++; $display("FAIL glitch cyc%0d q=%h r=%h f=%h c=%h want 0", k, qB, riseB, fallB, chgB);
      end
    end
  endtask

  task automatic test_filter_latency();
    dB = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (qB[0] !== (k >= 7) || riseB[0] !== (k == 7) || chgB[0] !== (k == 7) || fallB[0] !== 1'b0) begin
        errors++; $display("FAIL filt_rise cyc%0d q=%b r=%b c=%b want q=%b r=%b", k, qB[0], riseB[0],
                           chgB[0], k >= 7, k == 7);
      end
    end
    dB = 4'h0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (qB[0] !== (k < 7) || fallB[0] !== (k == 7) || riseB[0] !== 1'b0) begin
        errors++; $display("FAIL filt_fall cyc%0d q=%b f=%b want q=%b f=%b", k, qB[0], fallB[0],
                           k < 7, k == 7);
      end
    end
  endtask

  task automatic test_bounce();
    int nrise;
    nrise = 0;
    for (int k = 1; k <= 16; k++) begin
      dB[0] = (k <= 3) || (k >= 5);
      tick();
      if (riseB[0] === 1'b1) nrise++;
      checks++;
      if (riseB[0] !== (k == 11) || qB[0] !== (k >= 11)) begin
        errors++; $display("FAIL bounce cyc%0d r=%b q=%b want r=%b q=%b", k, riseB[0], qB[0],
                           k == 11, k >= 11);
      end
    end
    checks++;
    if (nrise != 1) begin
      errors++; $display("FAIL bounce_count got %0d want 1", nrise);
    end
    dB = 4'h0;
    repeat (10) tick();
  endtask

  task automatic test_rstval_fall();
    dC = 4'b1011;
    tick();
    checks++;
    if (qC !== 4'hF || fallC !== 4'h0) begin
      errors++; $display("FAIL rstval_e1 q=%h f=%h want f 0", qC, fallC);
    end
    tick();
    checks++;
    if (qC !== 4'b1011 || fallC !== 4'b0100 || riseC !== 4'h0 || chgC !== 4'b0100) begin
      errors++; $display("FAIL rstval_fall q=%h r=%h f=%h c=%h want b 0 4 4", qC, riseC, fallC, chgC);
    end
    tick();
    checks++;
    if (fallC !== 4'h0 || chgC !== 4'h0) begin
      errors++; $display("FAIL rstval_width f=%h c=%h want 0 0", fallC, chgC);
    end
  endtask

  task automatic test_mid_reset();
    dB = 4'b0001;
    repeat (5) tick();   // filter counter now at 2
    checks++;
    if (qB[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_pre q=%b want 0", qB[0]);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (qB !== 4'h0 || riseB !== 4'h0 || fallB !== 4'h0 || chgB !== 4'h0) begin
      errors++; $display("FAIL midrst_async q=%h r=%h f=%h c=%h want 0", qB, riseB, fallB, chgB);
    end
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (qB[0] !== (k >= 7) || riseB[0] !== (k == 7)) begin
        errors++; $display("FAIL midrst_relat cyc%0d q=%b r=%b want q=%b r=%b", k, qB[0], riseB[0],
                           k >= 7, k == 7);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_glitch();
    test_filter_latency();
    test_bounce();
    test_rstval_fall();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
